uart_rx_ctrl: RTL and testbench

- UART receive controller: sequences the RX datapath around the oversampling majority-vote sampler.
- Detects the start bit and runs the per-bit edge counter that drives the sampler's `edge_cnt` and `data_samp_en`.
- Collects the sampler's `sampled_bit` into a byte; checks parity and stop bits; reports the received frame.
- Sits between the RX pin synchroniser and the RX-side clock-domain-crossing logic.

---
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_rx_ctrl.sv | 114 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX controller and its surroundings:
// pin synchroniser, majority-vote sampler and the RX-side CDC logic.
interface uart_rx_ctrl_if #(
   parameter int unsigned DATA_W = 8
);
   logic              rx_in;
   logic [5:0]        prescalar;
   logic              par_en;
   logic              par_typ;
   logic              sampled_bit;
   logic              data_samp_en;
   logic [5:0]        edge_cnt;
   logic [DATA_W-1:0] p_data;
   logic              data_valid;
   logic              par_err;
   logic              stp_err;
   logic              busy;

   modport master (
      output rx_in, prescalar, par_en, par_typ, sampled_bit,
      input  data_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err, busy
   );

   modport slave (
      input  rx_in, prescalar, par_en, par_typ, sampled_bit,
      output data_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err, busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, per-bit edge counting, byte assembly,
// parity/stop checking. Define UART_RX_START_GLITCH_EN to abort on a false start bit.
module uart_rx_ctrl #(
   parameter int unsigned DATA_W = 8
) (
   input logic          clk,
   input logic          rst,
   uart_rx_ctrl_if.slave bus
);
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_nxt;
   logic [5:0]        edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] p_data;
   logic [5:0]        presc_q;
   logic              par_en_q, par_typ_q, par_flag;
   logic              data_valid, par_err, stp_err;
   logic              bit_end;

   assign bit_end = (edge_cnt == presc_q - 6'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (!bus.rx_in) state_nxt = START;
         START:
            if (bit_end) begin
`ifdef UART_RX_START_GLITCH_EN
               state_nxt = bus.sampled_bit ? IDLE : DATA;
`else
               state_nxt = DATA;
`endif
            end
         DATA:   if (bit_end && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
         PARITY: if (bit_end) state_nxt = STOP;
         STOP:   if (bit_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy         = (state != IDLE);
      bus.data_samp_en = (state != IDLE);
   end

   // The IDLE cycle that sees rx_in low is edge 0 of the start bit, hence edge_cnt <= 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         par_flag   <= 1'b0;
         presc_q    <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         if (state == IDLE) begin
            bit_cnt <= '0;
            if (!bus.rx_in) begin
               edge_cnt  <= 6'd1;
               presc_q   <= bus.prescalar;
               par_en_q  <= bus.par_en;
               par_typ_q <= bus.par_typ;
            end else begin
               edge_cnt <= '0;
            end
         end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;
            if (bit_end) begin
               case (state)
                  DATA: begin
                     shift   <= {bus.sampled_bit, shift[DATA_W-1:1]};
                     bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                  end
                  PARITY: par_flag <= (bus.sampled_bit != (par_typ_q ? ~^shift : ^shift));
                  STOP: begin
                     stp_err  <= ~bus.sampled_bit;
                     par_err  <= par_flag;
                     par_flag <= 1'b0;
                     if (bus.sampled_bit && !par_flag) begin
                        data_valid <= 1'b1;
                        p_data     <= shift;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.edge_cnt   = edge_cnt;
   assign bus.p_data     = p_data;
   assign bus.data_valid = data_valid;
   assign bus.par_err    = par_err;
   assign bus.stp_err    = stp_err;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural sampler and a pulse scoreboard.
// Glitch expectations follow UART_RX_START_GLITCH_EN.
module tb_uart_rx_ctrl;
   logic clk = 1'b0;
   logic rst;

   uart_rx_ctrl_if #(.DATA_W(8)) bus ();

   uart_rx_ctrl #(.DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  kind;   // {stp_err, par_err, data_valid}
      logic [7:0]  data;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned cur_p = 8;
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Sampler stand-in: captures the pin at edge prescalar/2 + 2 of each bit.
   always @(posedge clk) begin
      if (rst) bus.sampled_bit <= 1'b1;
      else if (bus.data_samp_en && bus.edge_cnt == 6'(cur_p / 2 + 2)) bus.sampled_bit <= bus.rx_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (bus.data_valid || bus.par_err || bus.stp_err)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {29'd0, bus.stp_err, bus.par_err, bus.data_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind", {29'd0, bus.stp_err, bus.par_err, bus.data_valid}, {29'd0, e.kind});
            chk("pulse_cycle", cyc, e.due);
            chk("p_data", {24'd0, bus.p_data}, {24'd0, e.data});
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_samp_en"}, {31'd0, bus.data_samp_en}, 32'd0);
      chk({tag, "_edge_cnt"}, {26'd0, bus.edge_cnt}, 32'd0);
      chk({tag, "_p_data"}, {24'd0, bus.p_data}, 32'd0);
      chk({tag, "_pulses"}, {29'd0, bus.stp_err, bus.par_err, bus.data_valid}, 32'd0);
   endtask

   // Called at a negedge; frame starts in the current cycle T = cyc.
   task automatic send_frame(input int unsigned p, input logic pen, input logic ptyp,
                             input logic [7:0] d, input logic pbit, input logic stop);
      exp_t e;
      logic par_bad, good;
      bus.prescalar = 6'(p);
      bus.par_en    = pen;
      bus.par_typ   = ptyp;
      bus.rx_in     = 1'b0;
      cur_p         = p;
      par_bad = pen && (pbit != (ptyp ? ~^d : ^d));
      good    = stop && !par_bad;
      if (good) last_good = d;
      e.kind = {~stop, par_bad, good};
      e.data = last_good;
      e.due  = cyc + p * (pen ? 11 : 10);
      sb.push_back(e);
      repeat (p) @(negedge clk);
      // Mid-frame configuration changes must be ignored.
      bus.prescalar = 6'd16;
      bus.par_en    = ~pen;
      bus.par_typ   = ~ptyp;
      for (int i = 0; i < 8; i++) begin
         bus.rx_in = d[i];
         repeat (p) @(negedge clk);
      end
      if (pen) begin
         bus.rx_in = pbit;
         repeat (p) @(negedge clk);
      end
      bus.rx_in = stop;
      repeat (p) @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int unsigned t0;
      rst           = 1'b1;
      bus.rx_in     = 1'b1;
      bus.prescalar = 6'd8;
      bus.par_en    = 1'b0;
      bus.par_typ   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      idle(5);

      send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
      idle(4);
      send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
      idle(4);
      send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
      idle(4);
      send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
      idle(4);

      // Short low glitch on the line.
      bus.prescalar = 6'd8;
      bus.par_en    = 1'b0;
      cur_p         = 8;
      bus.rx_in     = 1'b0;
      t0            = cyc;
`ifndef UART_RX_START_GLITCH_EN
      begin
         exp_t e;
         last_good = 8'hFF;
         e.kind = 3'b001;
         e.data = 8'hFF;
         e.due  = t0 + 80;
         sb.push_back(e);
      end
`endif
      repeat (3) @(negedge clk);
      bus.rx_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("glitch_busy_T7", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
`ifdef UART_RX_START_GLITCH_EN
      chk("glitch_busy_T8", {31'd0, bus.busy}, 32'd0);
`else
      chk("glitch_busy_T8", {31'd0, bus.busy}, 32'd1);
`endif
      repeat (76) @(negedge clk);

      // Reset during DATA bit 4.
      bus.prescalar = 6'd8;
      bus.par_en    = 1'b0;
      cur_p         = 8;
      bus.rx_in     = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.rx_in = i[0];
         repeat (8) @(negedge clk);
      end
      bus.rx_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
      check_reset_outputs("mid_rst");
      idle(5);
      send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
      idle(4);

      // Back-to-back frames at prescalar 32.
      send_frame(32, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1);
      send_frame(32, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1);
      idle(20);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end
endmodule
